msb_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one pipelined leading-one detector among `NREQ` requesters. It accepts 64-bit words from each requester over a valid/ready handshake and drives one word per cycle into the detector. It tracks in-flight words with a tag pipeline matched to the detector latency and returns each 8-bit MSB position to the requester that issued it. It sits between the requesting datapath blocks and the detector instance.

---
 rtl/msb_arbiter.sv | 107 ++++++++++
 tb/tb_msb_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msb_arbiter.sv
// Round-robin sharing of one pipelined MSB detector among NREQ requesters; a result returns
// DET_LAT+1 cycles after accept and waits in its slot until resp_ready (one word in flight per requester).
module msb_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW_IN   = 64,
  parameter int DET_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*DW_IN-1:0] req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic [DW_IN-1:0]    det_data,
  input  logic [7:0]          det_pos,
  output logic [NREQ-1:0]     resp_valid,
  output logic [NREQ*8-1:0]   resp_pos,
  input  logic [NREQ-1:0]     resp_ready,
  output logic                busy
);
  localparam int IDW = $clog2(NREQ);
  localparam int NST = DET_LAT + 1;

  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [DW_IN-1:0]        det_data_q, det_data_d;
  logic [NST-1:0]          tag_vld_q, tag_vld_d;
  logic [NST-1:0][IDW-1:0] tag_id_q, tag_id_d;
  logic [NREQ-1:0]         resp_valid_q, resp_valid_d;
  logic [NREQ*8-1:0]       resp_pos_q, resp_pos_d;
  logic                    busy_q, busy_d;

  logic [NREQ-1:0] in_flight;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            accept;

  // Search order is ptr+1, ptr+2, ... so the last winner has lowest priority next time.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int s = 0; s < NST; s++) begin
        if (tag_vld_q[s] && tag_id_q[s] == IDW'(i)) in_flight[i] = 1'b1;
      end
    end
    eligible = req_valid & ~in_flight & ~resp_valid_q;
    grant    = '0;
    grant_id = ptr_q;
    accept   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rst_n && !accept && eligible[i] && ((int'(ptr_q) + k) % NREQ) == i) begin
          accept   = 1'b1;
          grant[i] = 1'b1;
          grant_id = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    ptr_d      = accept ? grant_id : ptr_q;
    det_data_d = det_data_q;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) det_data_d = req_data[i*DW_IN +: DW_IN];
    end
    tag_vld_d = {tag_vld_q[NST-2:0], accept};
    tag_id_d  = {tag_id_q[NST-2:0], grant_id};

    // Capture and consume cannot hit the same slot: a requester with a tag in flight is never valid.
    resp_valid_d = resp_valid_q & ~resp_ready;
    resp_pos_d   = resp_pos_q;
    for (int i = 0; i < NREQ; i++) begin
      if (tag_vld_q[DET_LAT] && tag_id_q[DET_LAT] == IDW'(i)) begin
        resp_valid_d[i]      = 1'b1;
        resp_pos_d[i*8 +: 8] = det_pos;
      end
    end
    busy_d = (|tag_vld_d) | (|resp_valid_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q        <= IDW'(NREQ - 1);
      det_data_q   <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      resp_valid_q <= '0;
      resp_pos_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      det_data_q   <= det_data_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      resp_valid_q <= resp_valid_d;
      resp_pos_q   <= resp_pos_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready  = grant;
  assign det_data   = det_data_q;
  assign resp_valid = resp_valid_q;
  assign resp_pos   = resp_pos_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_msb_arbiter.sv
// Bench for msb_arbiter: detector model, high-level grant/outstanding predictor and a response scoreboard.
module tb_msb_arbiter;
  localparam int NREQ    = 4;
  localparam int DW_IN   = 64;
  localparam int DET_LAT = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DW_IN-1:0]  req_data;
  logic [NREQ-1:0]        req_ready;
  logic [DW_IN-1:0]       det_data;
  logic [7:0]             det_pos = 8'd0;
  logic [7:0]             det_s1 = 8'd0;
  logic [NREQ-1:0]        resp_valid;
  logic [NREQ*8-1:0]      resp_pos;
  logic [NREQ-1:0]        resp_ready;
  logic                   busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit armed = 1'b0;

  typedef struct {
    int         id;
    logic [7:0] pos;
    int         due;
  } exp_t;
  exp_t scq[$];

  logic [DW_IN-1:0] w0;
  bit               use_w0 = 1'b0;
  logic [63:0]      singles [4] = '{64'h1, 64'h8000_0000_0000_0000, 64'h0, 64'h0000_0100_0000_0000};

  msb_arbiter #(.NREQ(NREQ), .DW_IN(DW_IN), .DET_LAT(DET_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .det_data   (det_data),
    .det_pos    (det_pos),
    .resp_valid (resp_valid),
    .resp_pos   (resp_pos),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Highest set bit, 1-based; 0 for an all-zero word.
  function automatic logic [7:0] msb_pos(input logic [DW_IN-1:0] w);
    for (int b = DW_IN - 1; b >= 0; b--) begin
      if (w[b]) return 8'(b + 1);
    end
    return 8'd0;
  endfunction

  // Two-stage detector standing in for the shared leading-one detector.
  always @(posedge clk) begin
    det_s1  <= msb_pos(det_data);
    det_pos <= det_s1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW_IN-1:0] rnd_word();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w >> $urandom_range(0, DW_IN);
  endfunction

  task automatic drive(input bit r, input logic [NREQ-1:0] v, input logic [NREQ-1:0] rr, input int n);
    repeat (n) begin
      @(negedge clk);
      rst_n      = r;
      req_valid  = v;
      resp_ready = rr;
      for (int i = 0; i < NREQ; i++) req_data[i*DW_IN +: DW_IN] = rnd_word();
      if (use_w0) req_data[DW_IN-1:0] = w0;
    end
  endtask

  // Predictor: tracks which requesters have a word outstanding and who should win next.
  initial begin : predictor
    logic [NREQ-1:0]  exp_rdy;
    logic [NREQ-1:0]  outst;
    logic [NREQ-1:0]  vis;
    logic [DW_IN-1:0] exp_det;
    int               due_r [NREQ];
    int               last;
    int               best;
    int               rank;
    exp_t             e;
    outst   = '0;
    exp_det = '0;
    last    = NREQ - 1;
    for (int i = 0; i < NREQ; i++) due_r[i] = 0;
    forever begin
      @(negedge clk);
      #3;
      for (int i = 0; i < NREQ; i++) vis[i] = outst[i] && (cyc >= due_r[i]);
      exp_rdy = '0;
      best    = NREQ;
      if (rst_n) begin
        for (int i = 0; i < NREQ; i++) begin
          rank = (i - last - 1 + 2 * NREQ) % NREQ;
          if (req_valid[i] && !outst[i] && rank < best) best = rank;
        end
        if (best < NREQ) exp_rdy[(last + 1 + best) % NREQ] = 1'b1;
      end
      if (armed) begin
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("busy", 64'(busy), 64'(|outst));
        chk("det_data", 64'(det_data), 64'(exp_det));
      end
      if (!rst_n) begin
        outst   = '0;
        last    = NREQ - 1;
        exp_det = '0;
        scq.delete();
        armed   = 1'b1;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (vis[i] && resp_ready[i]) outst[i] = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
          if (exp_rdy[i]) begin
            outst[i] = 1'b1;
            due_r[i] = cyc + DET_LAT + 2;
            last     = i;
            exp_det  = req_data[i*DW_IN +: DW_IN];
            e.id     = i;
            e.pos    = msb_pos(exp_det);
            e.due    = due_r[i];
            scq.push_back(e);
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a result slot becomes valid.
  initial begin : monitor
    logic [NREQ-1:0] prev_rv;
    logic [NREQ-1:0] prev_rr;
    logic [7:0]      held [NREQ];
    bit              rst_prev;
    exp_t            e;
    prev_rv  = '0;
    prev_rr  = '0;
    rst_prev = 1'b1;
    for (int i = 0; i < NREQ; i++) held[i] = 8'd0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_prev) begin
        prev_rv = '0;
        for (int i = 0; i < NREQ; i++) held[i] = 8'd0;
      end
      if (armed) begin
        if (rst_prev) chk("reset_resp_valid", 64'(resp_valid), 64'(0));
        for (int i = 0; i < NREQ; i++) begin
          if (!rst_prev && prev_rv[i] && !prev_rr[i])
            chk("resp_valid_held", 64'(resp_valid[i]), 64'(1));
          if (resp_valid[i] && !prev_rv[i]) begin
            chk("resp_expected", 64'(scq.size() > 0), 64'(1));
            if (scq.size() > 0) begin
              e = scq.pop_front();
              chk("resp_id", 64'(i), 64'(e.id));
              chk("resp_pos", 64'(resp_pos[i*8 +: 8]), 64'(e.pos));
              chk("resp_latency", 64'(cyc), 64'(e.due));
              held[i] = e.pos;
            end
          end
          chk("resp_pos_stable", 64'(resp_pos[i*8 +: 8]), 64'(held[i]));
        end
      end
      prev_rv  = resp_valid;
      prev_rr  = resp_ready;
      rst_prev = !rst_n;
    end
  end

  initial begin : stimulus
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    req_data   = '0;
    w0         = '0;
    drive(1'b0, '0, '0, 3);

    // Single requests on requester 0: pos 1, 64, 0, 41.
    for (int s = 0; s < 4; s++) begin
      w0     = singles[s];
      use_w0 = 1'b1;
      drive(1'b1, 4'b0001, '1, 1);
      use_w0 = 1'b0;
      drive(1'b1, '0, '1, 6);
    end

    // Round robin from reset: grants 0,1,2,3.
    drive(1'b0, '0, '1, 2);
    drive(1'b1, '1, '1, 14);
    drive(1'b1, '0, '1, 6);

    // Requester 2 backpressures, then releases for one cycle.
    drive(1'b1, '1, 4'b1011, 16);
    drive(1'b1, '1, 4'b1111, 1);
    drive(1'b1, '1, 4'b1011, 6);
    drive(1'b1, '0, '1, 8);

    // Fairness between requesters 1 and 3.
    drive(1'b1, 4'b1010, '1, 20);
    drive(1'b1, '0, '1, 6);

    // Reset while words from 0 and 1 are in flight.
    drive(1'b1, 4'b0011, '1, 2);
    drive(1'b1, '0, '1, 1);
    drive(1'b0, '0, '1, 1);
    drive(1'b1, '1, '1, 6);
    drive(1'b1, '0, '1, 6);

    // Capture of requester 1 on the same edge requester 2 is accepted.
    drive(1'b1, 4'b0010, '1, 1);
    drive(1'b1, '0, '1, 2);
    drive(1'b1, 4'b0100, '1, 1);
    drive(1'b1, '0, '1, 8);

    // Random traffic with occasional resets.
    repeat (2000) begin
      drive($urandom_range(0, 199) != 0, NREQ'($urandom()), NREQ'($urandom() | $urandom()), 1);
    end

    drive(1'b1, '0, '1, 12);
    chk("drain_empty", 64'(scq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
